// File: rtl/fnd_pkg.sv
// Shared types and digit limits for the FND stopwatch datapath.
package fnd_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MSEC_MAX  = 4'd9;
  localparam bcd_t SEC1_MAX  = 4'd9;
  localparam bcd_t SEC10_MAX = 4'd5;

  // Next value of a BCD digit that wraps to 0 after reaching max.
  function automatic bcd_t bcd_wrap(bcd_t d, bcd_t max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
// DIV must be at least 2.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Holds its phase while disabled so a pause loses no partial tick.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (cnt == LAST);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: run/stop/clear FSM driving a 4-digit BCD chain
// (SS.cc, 10 ms resolution, 00.00..59.99) from a prescaled tick.
//
//   state | meaning
//   STOP  | digits and prescaler frozen; i_clear wins over i_run_stop
//   RUN   | prescaler counting, digits advance on each tick
//   CLEAR | one cycle: zero digits and prescaler, then back to STOP
module stopwatch_counter
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_run_stop,
  input  logic       i_clear,
  output logic [3:0] o_msec_1,
  output logic [3:0] o_msec_10,
  output logic [3:0] o_sec_1,
  output logic [3:0] o_sec_10,
  output logic       o_running,
  output logic       o_tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  sw_state_e state_q, state_d;
  logic      tick_cond;
  logic      tick_q;
  bcd_t      msec_1_q, msec_10_q, sec_1_q, sec_10_q;
  bcd_t      msec_1_d, msec_10_d, sec_1_d, sec_10_d;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (state_q == RUN),
    .i_clr     (state_q == CLEAR),
    .o_tick    (tick_cond)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP: begin
        if (i_clear) begin
          state_d = CLEAR;
        end else if (i_run_stop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_run_stop) begin
          state_d = STOP;
        end
      end
      CLEAR:   state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // Ripple carry through all four digits in one cycle.
  always_comb begin
    msec_1_d  = msec_1_q;
    msec_10_d = msec_10_q;
    sec_1_d   = sec_1_q;
    sec_10_d  = sec_10_q;
    if (tick_cond) begin
      msec_1_d = bcd_wrap(msec_1_q, MSEC_MAX);
      if (msec_1_q == MSEC_MAX) begin
        msec_10_d = bcd_wrap(msec_10_q, MSEC_MAX);
        if (msec_10_q == MSEC_MAX) begin
          sec_1_d = bcd_wrap(sec_1_q, SEC1_MAX);
          if (sec_1_q == SEC1_MAX) begin
            sec_10_d = bcd_wrap(sec_10_q, SEC10_MAX);
          end
        end
      end
    end
  end

  // A tick coinciding with a stop request still counts: tick_cond is
  // evaluated from the current RUN state, not the next one.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      msec_1_q  <= '0;
      msec_10_q <= '0;
      sec_1_q   <= '0;
      sec_10_q  <= '0;
      tick_q    <= 1'b0;
    end else if (state_q == CLEAR) begin
      msec_1_q  <= '0;
      msec_10_q <= '0;
      sec_1_q   <= '0;
      sec_10_q  <= '0;
      tick_q    <= 1'b0;
    end else begin
      msec_1_q  <= msec_1_d;
      msec_10_q <= msec_10_d;
      sec_1_q   <= sec_1_d;
      sec_10_q  <= sec_10_d;
      tick_q    <= tick_cond;
    end
  end

  assign o_msec_1  = msec_1_q;
  assign o_msec_10 = msec_10_q;
  assign o_sec_1   = sec_1_q;
  assign o_sec_10  = sec_10_q;
  assign o_running = (state_q == RUN);
  assign o_tick    = tick_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboard bench for stopwatch_counter with DIV = 10 (CLK_HZ=1000, TICK_HZ=100).
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run_stop = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] msec_1, msec_10, sec_1, sec_10;
  logic       running, tick;
  logic [15:0] disp;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  int          exp_cs = 0;
  int          cyc = 0;
  int          last_tick_cyc = -1;
  bit          gap_chk = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_run_stop (run_stop),
    .i_clear    (clr),
    .o_msec_1   (msec_1),
    .o_msec_10  (msec_10),
    .o_sec_1    (sec_1),
    .o_sec_10   (sec_10),
    .o_running  (running),
    .o_tick     (tick)
  );

  assign disp = {sec_10, sec_1, msec_10, msec_1};

  function automatic logic [15:0] cs_to_bcd(int cs);
    int c;
    c = cs % 6000;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ticks(int n);
    for (int i = 0; i < n; i++) begin
      exp_cs++;
      exp_q.push_back(cs_to_bcd(exp_cs));
    end
  endtask

  // Caller is at a negedge; inputs are captured by the next posedge.
  task automatic pulse(input logic rs, input logic cl);
    run_stop = rs;
    clr = cl;
    @(negedge clk);
    run_stop = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && tick) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick: got digits %h expected no tick", disp);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tick_digits", {16'h0, disp}, {16'h0, mon_exp});
      end
      if (gap_chk && last_tick_cyc >= 0)
        check("tick_spacing", cyc - last_tick_cyc, 10);
      last_tick_cyc = cyc;
    end
  end

  initial begin
    #(10 * 200_000);
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_digits", {16'h0, disp}, 32'h0);
    check("rst_running", {31'h0, running}, 32'h0);
    check("rst_tick", {31'h0, tick}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_running", {31'h0, running}, 32'h0);

    // 100 clocks of RUN: ten ticks, ten clocks apart
    pulse(1'b1, 1'b0);
    push_ticks(10);
    gap_chk = 1'b1;
    idle(100);
    gap_chk = 1'b0;
    check("p1_digits", {16'h0, disp}, 32'h0010);
    check("p1_running", {31'h0, running}, 32'h1);
    #1 check("p1_drained", exp_q.size(), 0);

    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    idle(1);
    exp_cs = 0;
    check("clr1_digits", {16'h0, disp}, 32'h0);
    check("clr1_running", {31'h0, running}, 32'h0);

    // run 25, stop, idle 50, run 5 more
    pulse(1'b1, 1'b0);
    push_ticks(2);
    idle(24);
    pulse(1'b1, 1'b0);
    check("pause_running", {31'h0, running}, 32'h0);
    for (int i = 0; i < 50; i++) begin
      check("pause_frozen", {16'h0, disp}, 32'h0002);
      @(negedge clk);
    end
    pulse(1'b1, 1'b0);
    push_ticks(1);
    idle(5);
    check("resume_digits", {16'h0, disp}, 32'h0003);
    check("resume_running", {31'h0, running}, 32'h1);

    // stop request lands on the tick condition at 00.04
    push_ticks(2);
    idle(19);
    pulse(1'b1, 1'b0);
    check("collide_digits", {16'h0, disp}, 32'h0005);
    check("collide_running", {31'h0, running}, 32'h0);
    idle(20);
    check("collide_frozen", {16'h0, disp}, 32'h0005);

    // clear and run_stop together in STOP
    pulse(1'b1, 1'b1);
    check("clear_state_running", {31'h0, running}, 32'h0);
    check("clear_state_digits", {16'h0, disp}, 32'h0005);
    idle(1);
    exp_cs = 0;
    check("clear_digits", {16'h0, disp}, 32'h0);
    check("clear_running", {31'h0, running}, 32'h0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    idle(3);
    check("run_in_clear_ignored", {31'h0, running}, 32'h0);

    // clear during RUN is ignored
    pulse(1'b1, 1'b0);
    push_ticks(1);
    idle(14);
    pulse(1'b0, 1'b1);
    check("run_clear_running", {31'h0, running}, 32'h1);
    check("run_clear_digits", {16'h0, disp}, 32'h0001);
    idle(3);
    pulse(1'b1, 1'b0);
    check("stop2_digits", {16'h0, disp}, 32'h0001);
    pulse(1'b0, 1'b1);
    idle(1);
    exp_cs = 0;
    check("clr2_digits", {16'h0, disp}, 32'h0);

    // long run: 00.09->00.10, 09.99->10.00, 59.99->00.00, on to 12.34
    pulse(1'b1, 1'b0);
    push_ticks(7234);
    idle(72340);
    check("long_digits", {16'h0, disp}, 32'h1234);
    check("long_running", {31'h0, running}, 32'h1);
    #1 check("long_drained", exp_q.size(), 0);
    @(negedge clk);
    pulse(1'b1, 1'b0);
    check("long_stop_running", {31'h0, running}, 32'h0);
    idle(20);
    check("long_stop_frozen", {16'h0, disp}, 32'h1234);
    pulse(1'b1, 1'b0);
    push_ticks(1893);
    idle(18929);
    check("pre_rst_digits", {16'h0, disp}, 32'h3127);
    check("pre_rst_running", {31'h0, running}, 32'h1);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_digits", {16'h0, disp}, 32'h0);
    check("async_rst_running", {31'h0, running}, 32'h0);
    check("async_rst_tick", {31'h0, tick}, 32'h0);
    exp_q.delete();
    exp_cs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("after_rst_running", {31'h0, running}, 32'h0);
    check("after_rst_digits", {16'h0, disp}, 32'h0);
    #1 check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Upstream time base for the 4-digit FND stopwatch display.
- Divides the system clock into a centisecond tick.
- Counts elapsed time in BCD as four digits: sec_10, sec_1, msec_10, msec_1. Display resolution is 10 ms; range is 00.00 to 59.99 s.
- Digits feed the FND digit-select multiplexer directly. A small FSM controls run, stop and clear.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count-tick rate in Hz (one LSB = 10 ms).
- DIV = CLK_HZ/TICK_HZ, derived localparam, prescaler modulus; must be ≥ 2.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_run_stop  input  1  one-cycle pulse (already debounced and edge-detected); toggles run/stop.
- i_clear  input  1  one-cycle pulse; zeroes time while stopped.
- o_msec_1  output  4  BCD 0-9, 10 ms digit.
- o_msec_10  output  4  BCD 0-9, 100 ms digit.
- o_sec_1  output  4  BCD 0-9, 1 s digit.
- o_sec_10  output  4  BCD 0-5, 10 s digit.
- o_running  output  1  high while in RUN.
- o_tick  output  1  one-cycle pulse each time the digit chain advances.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - All digits = 0, prescaler = 0, state = STOP.
  - o_running = 0, o_tick = 0.
  - Release is synchronous to the next i_clk edge.
- FSM states: STOP, RUN, CLEAR. Encoding is 2 bits: STOP=0, RUN=1, CLEAR=2.
- STOP transitions:
  - i_clear → CLEAR (clear has priority over i_run_stop in the same cycle).
  - Otherwise i_run_stop → RUN.
  - Otherwise stay in STOP.
- RUN transitions:
  - i_run_stop → STOP.
  - i_clear is ignored in RUN.
- CLEAR lasts exactly one cycle:
  - Zeroes the digits and the prescaler.
  - Then → STOP unconditionally; an i_run_stop pulse during CLEAR is ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and wraps to 0.
  - Holds its value in STOP, so a pause/resume loses no partial tick.
  - The tick condition is prescaler == DIV-1 while in RUN.
- o_tick:
  - Registered; asserted for one cycle, one cycle after the tick condition.
  - The digits update on the same edge that asserts o_tick. Latency from the tick condition to new digits is 1 clock.
- Stop/tick collision: if i_run_stop arrives in the same cycle as the tick condition, the tick still counts and the state goes to STOP.
- Digit chain, ripple carry within a single cycle:
  - msec_1 increments; at 9 it wraps to 0 and carries.
  - msec_10 wraps 9→0 and carries.
  - sec_1 wraps 9→0 and carries.
  - sec_10 wraps 5→0.
  - 59.99 + 1 tick = 00.00; counting continues (no saturation, no overflow flag).
- Width rules: digit registers are 4 bits and never leave their legal range. The prescaler width is $clog2(DIV).
- o_running = (state == RUN), decoded from the registered state.
- Reset mid-run: everything returns to the reset values immediately, regardless of prescaler phase.

Decomposition:
- Shared package fnd_pkg holds:
  - the state typedef (STOP/RUN/CLEAR);
  - digit limit constants MSEC_MAX=9, SEC1_MAX=9, SEC10_MAX=5;
  - a 4-bit BCD digit typedef, reused by the FND mux and the segment decoder.
- Sub-module tick_gen (parameter DIV; ports i_clk, i_reset_n, i_en, i_clr, o_tick):
  - holds the prescaler;
  - stopwatch_counter holds the FSM and the BCD chain.

Test Plan (CLK_HZ=1000, TICK_HZ=100 → DIV=10):
- Reset, then i_run_stop pulse, run 100 clocks → digits 0,0,1,0 (sec_10..msec_1 = 00.10); o_tick pulsed 10 times, exactly every 10 clocks; o_running=1.
- Run 25 clocks, stop, idle 50, run 5 more clocks → 00.03; digits frozen during the idle period.
- Force count to 00.09, then one tick → 00.10. From 09.99 → 10.00. From 59.99 → 00.00, with o_tick still pulsing.
- In STOP at 12.34, i_clear and i_run_stop pulsed together → CLEAR for 1 cycle, then STOP at 00.00 with o_running=0. An i_clear issued during RUN leaves the count untouched.
- i_run_stop in the same cycle as the tick condition at 00.04 → display 00.05, state STOP.
- Assert i_reset_n=0 mid-run at 31.27, asynchronously between clock edges → outputs are zero before the next edge; after release the block stays in STOP.
